// File: rtl/word_stack.sv
// rtl/word_stack.sv - word-wide calculator stack, entry 0 is TOS; WORD_STACK_GUARD_EN enables the sticky err guard
module word_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [2:0]                 mode,
  input  logic [WIDTH-1:0]           d,
  output logic [WIDTH-1:0]           tos,
  output logic [WIDTH-1:0]           nos,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       err
);
  localparam int CW = $clog2(DEPTH+1);
`ifdef WORD_STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef enum logic [2:0] {
    OP_IDLE  = 3'b000,
    OP_PUSH  = 3'b001,
    OP_POP   = 3'b010,
    OP_SWAP  = 3'b011,
    OP_DUP   = 3'b100,
    OP_OVER  = 3'b101,
    OP_ROT   = 3'b110,
    OP_RESET = 3'b111
  } op_e;

  op_e              op;
  logic [WIDTH-1:0] mem    [DEPTH];
  logic [WIDTH-1:0] mem_nx [DEPTH];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_nx;
  logic             illegal;

  assign op    = op_e'(mode);
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign tos   = mem[0];
  assign nos   = mem[1];

  always_comb begin
    illegal = 1'b0;
    case (op)
      OP_PUSH: illegal = full;
      OP_POP:  illegal = empty;
      OP_SWAP: illegal = (count_q < CW'(2));
      OP_DUP:  illegal = empty || full;
      OP_OVER: illegal = (count_q < CW'(2)) || full;
      OP_ROT:  illegal = (count_q < CW'(3));
      default: illegal = 1'b0;
    endcase
  end

  always_comb begin
    mem_nx   = mem;
    count_nx = count_q;
    if (!(illegal && GUARD)) begin
      case (op)
        OP_PUSH, OP_DUP, OP_OVER: begin
          for (int i = DEPTH - 1; i > 0; i--) mem_nx[i] = mem[i-1];
          if (op == OP_PUSH)     mem_nx[0] = d;
          else if (op == OP_DUP) mem_nx[0] = mem[0];
          else                   mem_nx[0] = mem[1];
          if (!full) count_nx = count_q + CW'(1);
        end
        OP_POP: begin
          if (!empty) begin
            for (int i = 0; i < DEPTH - 1; i++) mem_nx[i] = mem[i+1];
            mem_nx[DEPTH-1] = '0;
            count_nx = count_q - CW'(1);
          end
        end
        OP_SWAP: begin
          mem_nx[0] = mem[1];
          mem_nx[1] = mem[0];
        end
        OP_ROT: begin
          mem_nx[0] = mem[2];
          mem_nx[1] = mem[0];
          mem_nx[2] = mem[1];
        end
        OP_RESET: begin
          for (int i = 0; i < DEPTH; i++) mem_nx[i] = '0;
          count_nx = '0;
        end
        default: ;
      endcase
    end
    // Short-stack SWAP/ROT would leak data above count; keep unused slots zero.
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) >= count_nx) mem_nx[i] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= mem_nx[i];
      count_q <= count_nx;
    end
  end

`ifdef WORD_STACK_GUARD_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (rst || op == OP_RESET) err_q <= 1'b0;
    else if (illegal)          err_q <= 1'b1;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_word_stack.sv
// tb/tb_word_stack.sv - bench for word_stack (WIDTH=8, DEPTH=4): queue model plus directed scenarios
module tb_word_stack;
  localparam int DEPTH = 4;
`ifdef WORD_STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  localparam logic [2:0] IDLE = 3'd0, PUSH = 3'd1, POP = 3'd2, SWAP = 3'd3,
                         DUP = 3'd4, OVER = 3'd5, ROT = 3'd6, RST = 3'd7;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] mode;
  logic [7:0] d;
  logic [7:0] tos, nos;
  logic [2:0] count;
  logic       empty, full, err;

  int  n_cmp = 0;
  int  n_bad = 0;
  bit  chk_en = 1'b0;

  logic [7:0] mq[$];
  bit         merr;

  word_stack #(.WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .mode(mode), .d(d),
    .tos(tos), .nos(nos), .count(count),
    .empty(empty), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_top(input logic [7:0] x);
    mq.push_front(x);
    if (mq.size() > DEPTH) void'(mq.pop_back());
  endtask

  // Stack semantics on a queue: short stacks read as zero-padded, result trimmed to count.
  task automatic model_step(input bit r, input logic [2:0] m, input logic [7:0] dv);
    int         n;
    bit         ill;
    logic [7:0] v[DEPTH];
    logic [7:0] t;
    n = mq.size();
    if (r || m == RST) begin
      mq.delete();
      merr = 1'b0;
      return;
    end
    for (int i = 0; i < DEPTH; i++) v[i] = (i < n) ? mq[i] : 8'h00;
    case (m)
      PUSH:    ill = (n == DEPTH);
      POP:     ill = (n == 0);
      SWAP:    ill = (n < 2);
      DUP:     ill = (n < 1) || (n == DEPTH);
      OVER:    ill = (n < 2) || (n == DEPTH);
      ROT:     ill = (n < 3);
      default: ill = 1'b0;
    endcase
    if (ill && GUARD) begin
      merr = 1'b1;
      return;
    end
    case (m)
      PUSH: push_top(dv);
      POP:  if (n > 0) void'(mq.pop_front());
      DUP:  push_top(v[0]);
      OVER: push_top(v[1]);
      SWAP, ROT: begin
        if (m == SWAP) begin
          t = v[0]; v[0] = v[1]; v[1] = t;
        end else begin
          t = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t;
        end
        mq.delete();
        for (int i = 0; i < n; i++) mq.push_back(v[i]);
      end
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_tos",   tos,   (mq.size() > 0) ? mq[0] : 8'h00);
      check("m_nos",   nos,   (mq.size() > 1) ? mq[1] : 8'h00);
      check("m_count", count, mq.size());
      check("m_empty", empty, mq.size() == 0);
      check("m_full",  full,  mq.size() == DEPTH);
      check("m_err",   err,   merr);
    end
  end

  task automatic step(input bit r, input logic [2:0] m, input logic [7:0] dv);
    rst = r; mode = m; d = dv;
    @(posedge clk);
    model_step(r, m, dv);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0; mode = IDLE; d = 8'h00;
  endtask

  typedef struct { bit r; logic [2:0] m; logic [7:0] dv; } vec_t;
  vec_t mix[$];

  initial begin
    rst = 1'b1; mode = IDLE; d = 8'h00; merr = 1'b0;
    @(negedge clk);
    step(1'b1, IDLE, 8'h00);
    check("rst_tos", tos, 8'h00);   check("rst_nos", nos, 8'h00);
    check("rst_count", count, 0);   check("rst_empty", empty, 1);
    check("rst_full", full, 0);     check("rst_err", err, 0);

    step(0, PUSH, 8'h11); step(0, PUSH, 8'h22); step(0, PUSH, 8'h33);
    check("s1_tos", tos, 8'h33);    check("s1_nos", nos, 8'h22);
    check("s1_count", count, 3);    check("s1_empty", empty, 0);
    check("s1_full", full, 0);

    step(0, SWAP, 8'h00);
    check("s2_swap_tos", tos, 8'h22); check("s2_swap_nos", nos, 8'h33);
    step(0, ROT, 8'h00);
    check("s2_rot_tos", tos, 8'h11);  check("s2_rot_nos", nos, 8'h22);
    check("s2_rot_count", count, 3);
    step(0, POP, 8'h00);
    check("s2_third", nos, 8'h33);

    step(1, IDLE, 8'h00);
    step(0, PUSH, 8'h11); step(0, PUSH, 8'h22); step(0, PUSH, 8'h33);
    step(0, DUP, 8'h00);
    check("s3_dup_full", full, 1);  check("s3_dup_tos", tos, 8'h33);
    for (int i = 0; i < 4; i++) step(0, POP, 8'h00);
    check("s3_count", count, 0);    check("s3_empty", empty, 1);
    check("s3_tos", tos, 8'h00);    check("s3_nos", nos, 8'h00);

    step(1, IDLE, 8'h00);
    step(0, PUSH, 8'h11); step(0, PUSH, 8'h22); step(0, PUSH, 8'h33); step(0, PUSH, 8'h44);
    step(0, PUSH, 8'h55);
`ifdef WORD_STACK_GUARD_EN
    check("s4_tos", tos, 8'h44);    check("s4_nos", nos, 8'h33);
    check("s4_count", count, 4);    check("s4_err", err, 1);
    step(0, POP, 8'h00);
    check("s4_pop_count", count, 3); check("s4_pop_err", err, 1);
    step(0, RST, 8'h00);
    check("s4_rst_err", err, 0);    check("s4_rst_count", count, 0);
`else
    check("s5_tos", tos, 8'h55);    check("s5_nos", nos, 8'h44);
    check("s5_count", count, 4);    check("s5_err", err, 0);
    step(0, POP, 8'h00);
    check("s5_pop_tos", tos, 8'h44); check("s5_pop_nos", nos, 8'h33);
    step(0, RST, 8'h00);
    check("s5_rst_count", count, 0);
`endif
    step(0, POP, 8'h00);
    check("empty_pop_count", count, 0);
    check("empty_pop_err", err, GUARD);
    step(0, RST, 8'h00);

    step(0, PUSH, 8'h01);
    step(1, PUSH, 8'hAA);
    check("s6_count", count, 0);    check("s6_tos", tos, 8'h00);
    step(0, OVER, 8'h00);
    check("s6_over_count", count, GUARD ? 0 : 1);
    check("s6_over_err", err, GUARD);
    check("s6_over_tos", tos, 8'h00);

    mix = '{'{1, IDLE, 8'h00}, '{0, PUSH, 8'h05}, '{0, PUSH, 8'h06}, '{0, OVER, 8'h00},
            '{0, ROT, 8'h00}, '{0, SWAP, 8'h00}, '{0, DUP, 8'h00}, '{0, DUP, 8'h00},
            '{0, IDLE, 8'h00}, '{0, ROT, 8'h00}, '{0, POP, 8'h00}, '{0, SWAP, 8'h00},
            '{1, PUSH, 8'h07}, '{0, PUSH, 8'h08}, '{0, POP, 8'h00}, '{0, POP, 8'h00}};
    foreach (mix[i]) step(mix[i].r, mix[i].m, mix[i].dv);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
